// File: rtl/shader_pkg.sv
// Shared shader datapath constants: default register width and register-index width
// used by the vector register file and the SIMD datapath.
package shader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 3;

endpackage

// File: rtl/vector_register_file.sv
// Two-read, one-write vector register file with combinational reads and a
// synchronous clear; register 0 is an ordinary writable register.
module vector_register_file
  import shader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] vec_a,
  output logic [DATA_WIDTH-1:0] vec_b
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Reset outranks a concurrent write, so a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[write_addr] <= write_data;
    end
  end

  // No bypass: a pending write is only visible after the edge that commits it.
  always_comb begin
    vec_a = regs[addr_a];
    vec_b = regs[addr_b];
  end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed scenarios plus randomized
// traffic compared against an array model of the register contents.
module tb_vector_register_file;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] vec_a;
  logic [DW-1:0] vec_b;

  logic [DW-1:0] model [NR];
  int checks = 0;
  int failures = 0;

  vector_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk),
    .rst(rst),
    .write_enable(write_enable),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .write_addr(write_addr),
    .write_data(write_data),
    .vec_a(vec_a),
    .vec_b(vec_b)
  );

  always #5 clk = ~clk;

  // One rising edge; the model applies the register-file rules to the inputs held across it.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (write_enable) begin
      model[write_addr] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    step();
    write_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    addr_a = 3'd0;
    addr_b = 3'd1;
    #1;
    checks++;
    if (vec_a !== 32'h0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_vec_a actual=%h expected=00000000", vec_a);
    end
    checks++;
    if (vec_b !== 32'h0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_vec_b actual=%h expected=00000000", vec_b);
    end
    for (int i = 0; i < NR; i++) begin
      addr_a = AW'(i);
      addr_b = AW'(NR - 1 - i);
      #1;
      checks++;
      if (vec_a !== '0 || vec_b !== '0) begin
        failures++;
        $display("[TB] FAIL reset_all_%0d actual_a=%h actual_b=%h expected=00000000", i, vec_a, vec_b);
      end
    end
  endtask

  task automatic test_basic_writes();
    do_write(3'd3, 32'hDEAD_BEEF);
    do_write(3'd5, 32'hCAFE_BABE);
    addr_a = 3'd3;
    addr_b = 3'd5;
    #1;
    checks++;
    if (vec_a !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL basic_r3 actual=%h expected=DEADBEEF", vec_a);
    end
    checks++;
    if (vec_b !== 32'hCAFE_BABE) begin
      failures++;
      $display("[TB] FAIL basic_r5 actual=%h expected=CAFEBABE", vec_b);
    end
    addr_a = 3'd0;
    addr_b = 3'd1;
    #1;
    checks++;
    if (vec_a !== '0 || vec_b !== '0) begin
      failures++;
      $display("[TB] FAIL basic_untouched actual_a=%h actual_b=%h expected=00000000", vec_a, vec_b);
    end
  endtask

  task automatic test_write_disable();
    write_enable = 1'b0;
    write_addr   = 3'd3;
    write_data   = 32'h1234_5678;
    for (int i = 0; i < 4; i++) step();
    addr_a = 3'd3;
    #1;
    checks++;
    if (vec_a !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL write_disable_r3 actual=%h expected=DEADBEEF", vec_a);
    end
  endtask

  task automatic test_no_bypass();
    logic [DW-1:0] old_val;
    old_val      = model[2];
    addr_a       = 3'd2;
    addr_b       = 3'd7;
    write_enable = 1'b1;
    write_addr   = 3'd2;
    write_data   = 32'h1111_1111;
    #1;
    checks++;
    if (vec_a !== old_val) begin
      failures++;
      $display("[TB] FAIL no_bypass_before actual=%h expected=%h", vec_a, old_val);
    end
    step();
    write_enable = 1'b0;
    checks++;
    if (vec_a !== 32'h1111_1111) begin
      failures++;
      $display("[TB] FAIL no_bypass_after actual=%h expected=11111111", vec_a);
    end
    addr_b = 3'd2;
    #1;
    checks++;
    if (vec_a !== 32'h1111_1111 || vec_b !== 32'h1111_1111) begin
      failures++;
      $display("[TB] FAIL same_addr actual_a=%h actual_b=%h expected=11111111", vec_a, vec_b);
    end
  endtask

  task automatic test_reg0();
    do_write(3'd0, 32'hA5A5_A5A5);
    addr_a = 3'd0;
    addr_b = 3'd4;
    #1;
    checks++;
    if (vec_a !== 32'hA5A5_A5A5) begin
      failures++;
      $display("[TB] FAIL reg0_write actual=%h expected=A5A5A5A5", vec_a);
    end
  endtask

  task automatic test_back_to_back();
    do_write(3'd6, 32'h0000_0001);
    do_write(3'd6, 32'h0000_0002);
    do_write(3'd6, 32'h0000_0003);
    do_write(3'd1, 32'h0BAD_F00D);
    addr_a = 3'd6;
    addr_b = 3'd1;
    #1;
    checks++;
    if (vec_a !== 32'h0000_0003) begin
      failures++;
      $display("[TB] FAIL last_write_wins actual=%h expected=00000003", vec_a);
    end
    checks++;
    if (vec_b !== 32'h0BAD_F00D) begin
      failures++;
      $display("[TB] FAIL back_to_back_r1 actual=%h expected=0BADF00D", vec_b);
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < NR; i++) do_write(AW'(i), 32'h1000_0000 + DW'(i) * 32'h0101_0101);
    for (int i = 0; i < NR; i++) begin
      addr_a = AW'(i);
      #1;
      checks++;
      if (vec_a !== 32'h1000_0000 + DW'(i) * 32'h0101_0101) begin
        failures++;
        $display("[TB] FAIL fill_r%0d actual=%h expected=%h", i, vec_a, 32'h1000_0000 + DW'(i) * 32'h0101_0101);
      end
    end
    rst          = 1'b1;
    write_enable = 1'b1;
    write_addr   = 3'd4;
    write_data   = 32'hFFFF_FFFF;
    step();
    rst          = 1'b0;
    write_enable = 1'b0;
    for (int i = 0; i < NR; i++) begin
      addr_a = AW'(i);
      addr_b = AW'(i);
      #1;
      checks++;
      if (vec_a !== '0 || vec_b !== '0) begin
        failures++;
        $display("[TB] FAIL reset_priority_r%0d actual_a=%h actual_b=%h expected=00000000", i, vec_a, vec_b);
      end
    end
  endtask

  // Random traffic: reads are checked before each edge, so pending writes must not be visible yet.
  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      write_enable = ($urandom_range(0, 2) != 0);
      write_addr   = AW'($urandom_range(0, NR - 1));
      write_data   = $urandom;
      addr_a       = AW'($urandom_range(0, NR - 1));
      addr_b       = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, NR - 1));
      #1;
      checks++;
      if (vec_a !== model[addr_a] || vec_b !== model[addr_b]) begin
        failures++;
        $display("[TB] FAIL random_%0d actual_a=%h expected_a=%h actual_b=%h expected_b=%h",
                 n, vec_a, model[addr_a], vec_b, model[addr_b]);
      end
      step();
    end
    rst          = 1'b0;
    write_enable = 1'b0;
    for (int i = 0; i < NR; i++) begin
      addr_a = AW'(i);
      #1;
      checks++;
      if (vec_a !== model[i]) begin
        failures++;
        $display("[TB] FAIL random_final_r%0d actual=%h expected=%h", i, vec_a, model[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_writes();
    test_write_disable();
    test_no_bypass();
    test_reg0();
    test_back_to_back();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
